serial_add_sub: RTL and testbench

Bit-serial WIDTH-bit adder/subtractor built around the single-bit `full_adder_cum_subtractor` cell. It processes one bit per clock, LSB first. The block accepts a start request with two operands and a mode, then returns a WIDTH-bit result with carry/borrow and signed-overflow flags after WIDTH cycles. It sits where area matters more than throughput: one cell plus shift registers replaces a WIDTH-bit parallel adder.

---
 rtl/serial_add_sub_pkg.sv | 13 +
 rtl/full_adder_cum_subtractor.sv | 17 +
 rtl/serial_add_sub.sv | 98 +++++++++
 tb/tb_serial_add_sub.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder_cum_subtractor.sv
// Single-bit add/subtract cell: a + (b ^ mode) + cin.
module full_adder_cum_subtractor (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic mode,
  output logic sumdiff,
  output logic cout
);

  logic bx;

  assign bx      = b ^ mode;
  assign sumdiff = a ^ bx ^ cin;
  assign cout    = (a & bx) | (a & cin) | (bx & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one cell, LSB first, one bit per clock.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             mode_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             cell_sd;
  logic             cell_co;

  full_adder_cum_subtractor u_cell (
    .a       (a_sh[0]),
    .b       (b_sh[0]),
    .cin     (carry),
    .mode    (mode_q),
    .sumdiff (cell_sd),
    .cout    (cell_co)
  );

  // The carry register doubles as the cout output once the last bit is done.
  assign cout = carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      mode_q <= MODE_ADD;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            mode_q <= mode;
            carry  <= mode;
            cnt    <= '0;
            ovf    <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          result <= {cell_sd, result[WIDTH-1:1]};
          carry  <= cell_co;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Carry into the MSB xor carry out of the MSB flags signed overflow.
            ovf   <= carry ^ cell_co;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub with a cycle-level reference model.
module tb_serial_add_sub;
  import serial_add_sub_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: returns {ovf, cout, result}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic md);
    int ux, uy, u, sx, sy, s;
    logic [W-1:0] r;
    logic c, o;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (md == MODE_ADD) begin
      u = ux + uy;
      s = sx + sy;
      c = (u >= (1 << W));
    end else begin
      u = ux - uy;
      s = sx - sy;
      c = (ux >= uy);
    end
    r = u[W-1:0];
    o = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
    return {o, c, r};
  endfunction

  // Model: cyc = number of edges seen; an accepted start at edge k gives
  // busy after edges k..k+W, done after edge k+W, idle again from edge k+W+2.
  int             cyc = 0;
  int             k = 0;
  bit             active = 1'b0;
  bit             armed = 1'b0;
  logic [W+1:0]   m_pack = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      active <= 1'b0;
      armed  <= 1'b1;
      m_pack <= '0;
    end else if (start && (!active || (cyc + 1 >= k + W + 2))) begin
      active <= 1'b1;
      k      <= cyc + 1;
      m_pack <= ref_op(a, b, mode);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("busy", 32'(busy), 32'(active && (cyc <= k + W)));
      check("done", 32'(done), 32'(active && (cyc == k + W)));
      if (!active || (cyc >= k + W)) begin
        check("result", 32'(result), 32'(m_pack[W-1:0]));
        check("cout", 32'(cout), 32'(m_pack[W]));
        check("ovf", 32'(ovf), 32'(m_pack[W+1]));
      end
    end
  end

  task automatic do_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic md, input logic [W-1:0] lr, input logic lc, input logic lo);
    int n;
    @(negedge clk);
    a = x; b = y; mode = md; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); mode = ~md;
    n = 0;
    while (!done && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(W));
    check({name, "_result"}, 32'(result), 32'(lr));
    check({name, "_cout"}, 32'(cout), 32'(lc));
    check({name, "_ovf"}, 32'(ovf), 32'(lo));
    check({name, "_model"}, 32'(m_pack), 32'({lo, lc, lr}));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ndone;
    logic [W-1:0] cap;
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    do_op("add", 8'h5A, 8'h33, MODE_ADD, 8'h8D, 1'b0, 1'b1);
    do_op("add_wrap", 8'hFF, 8'h01, MODE_ADD, 8'h00, 1'b1, 1'b0);
    do_op("sub_borrow", 8'h10, 8'h20, MODE_SUB, 8'hF0, 1'b0, 1'b0);
    do_op("sub_ovf", 8'h80, 8'h01, MODE_SUB, 8'h7F, 1'b1, 1'b1);
    do_op("add_neg_ovf", 8'h80, 8'hFF, MODE_ADD, 8'h7F, 1'b1, 1'b1);
    do_op("sub_equal", 8'h3C, 8'h3C, MODE_SUB, 8'h00, 1'b1, 1'b0);

    // Start pulsed during RUN must be ignored.
    @(negedge clk);
    a = 8'h5A; b = 8'h33; mode = MODE_ADD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'h11; b = 8'h22; mode = MODE_SUB; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    cap = '0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        cap = result;
      end
    end
    check("ign_done_count", 32'(ndone), 32'd1);
    check("ign_result", 32'(cap), 32'h8D);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 8'hFF; b = 8'h01; mode = MODE_ADD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    ndone = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_rst_no_done", 32'(ndone), 32'd0);
    do_op("after_rst", 8'h10, 8'h20, MODE_SUB, 8'hF0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
